// File: rtl/sr_fifo_sync.sv
// Synchronous FIFO with occupancy count, almost flags, optional FWFT read and sticky errors.
// Ports: clk, reset (async high), wr_en/wr_data, rd_en/rd_data, clr_err, full, empty,
//        almost_full, almost_empty, count, overflow, underflow.
module sr_fifo_sync #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  parameter int FWFT       = 0,
  localparam int DEPTH     = 2 ** ADDR_WIDTH,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  clr_err,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = CW'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = CW'(AE_LEVEL);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic                  wa;
  logic                  ra;

  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // Acceptance is gated by the pre-edge flags; reset blocks all requests.
  assign wa = wr_en && !full && !reset;
  assign ra = rd_en && !empty && !reset;

  always_ff @(posedge clk) begin
    if (wa) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wa) wr_ptr <= wr_ptr + 1'b1;
      if (ra) rd_ptr <= rd_ptr + 1'b1;
      unique case ({wa, ra})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A new error in the same cycle as clr_err keeps the flag set.
      if (wr_en && full)  overflow <= 1'b1;
      else if (clr_err)   overflow <= 1'b0;
      if (rd_en && empty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is always presented; rd_en only advances the pointer.
      assign rd_data = mem[rd_ptr];
    end else begin : g_reg
      always_ff @(posedge clk or posedge reset) begin
        if (reset)   rd_data <= '0;
        else if (ra) rd_data <= mem[rd_ptr];
      end
    end
  endgenerate

endmodule

// File: tb/tb_sr_fifo_sync.sv
// Directed bench for sr_fifo_sync: one registered-read and one FWFT instance
// sharing stimulus; expected values are hand-computed or from a small queue.
module tb_sr_fifo_sync;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        rd_en;
  logic        clr_err;

  logic [31:0] rd_data0, rd_data1;
  logic        full0, empty0, af0, ae0, ov0, uf0;
  logic        full1, empty1, af1, ae1, ov1, uf1;
  logic [3:0]  count0, count1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] q[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  sr_fifo_sync #(.FWFT(0)) u_reg (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data0), .clr_err(clr_err),
    .full(full0), .empty(empty0), .almost_full(af0),
    .almost_empty(ae0), .count(count0),
    .overflow(ov0), .underflow(uf0)
  );

  sr_fifo_sync #(.FWFT(1)) u_ft (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data1), .clr_err(clr_err),
    .full(full1), .empty(empty1), .almost_full(af1),
    .almost_empty(ae1), .count(count1),
    .overflow(ov1), .underflow(uf1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = '0;
    rd_en   = 1'b0;
    clr_err = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(count0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_full",  32'(full0), 0);
    chk("rst_ae",    32'(ae0), 1);
    chk("rst_af",    32'(af0), 0);
    chk("rst_ov",    32'(ov0), 0);
    chk("rst_uf",    32'(uf0), 0);
    chk("rst_rd",    rd_data0, 0);
    reset = 1'b0;

    // Fill 0x11..0x88
    for (int i = 0; i < 8; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'((i + 1) * 32'h11);
      tick();
      chk("fill_count", 32'(count0), 32'(i + 1));
      chk("fill_ae",    32'(ae0), 32'(i + 1 <= 1));
      chk("fill_af",    32'(af0), 32'(i + 1 >= 6));
      chk("fill_full",  32'(full0), 32'(i == 7));
      chk("fill_ov",    32'(ov0), 0);
    end

    // Overflow and clear
    wr_data = 32'hDEAD;
    tick();
    chk("ovf_count", 32'(count0), 8);
    chk("ovf_flag",  32'(ov0), 1);
    wr_en   = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovf_clr", 32'(ov0), 0);

    // Drain with registered read
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      tick();
      chk("drain_data",  rd_data0, 32'((i + 1) * 32'h11));
      chk("drain_count", 32'(count0), 32'(7 - i));
    end
    chk("drain_empty", 32'(empty0), 1);
    tick();
    rd_en = 1'b0;
    chk("udf_flag", 32'(uf0), 1);
    chk("udf_data", rd_data0, 32'h88);
    chk("udf_ov",   32'(ov0), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("udf_clr", 32'(uf0), 0);

    // Move pointers to 5 and leave 3 words in slots 5..7
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h50 + 32'(i);
      q.push_back(wr_data);
      tick();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b1;
      tick();
      exp_v = q.pop_front();
      chk("pre_data", rd_data0, exp_v);
    end
    rd_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h60 + 32'(i);
      q.push_back(wr_data);
      tick();
    end
    chk("sim_start", 32'(count0), 3);

    // Simultaneous read/write across the pointer wrap
    for (int i = 0; i < 10; i++) begin
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 32'h100 + 32'(i);
      tick();
      exp_v = q.pop_front();
      q.push_back(wr_data);
      chk("sim_data",  rd_data0, exp_v);
      chk("sim_count", 32'(count0), 3);
      chk("sim_err",   32'({ov0, uf0}), 0);
    end
    wr_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd_en = 1'b1;
      tick();
      exp_v = q.pop_front();
      chk("sim_tail", rd_data0, exp_v);
    end
    rd_en = 1'b0;
    chk("sim_empty", 32'(empty0), 1);

    // FWFT: word visible without rd_en
    wr_en   = 1'b1;
    wr_data = 32'hA5;
    tick();
    wr_en = 1'b0;
    chk("ft_data",  rd_data1, 32'hA5);
    chk("ft_empty", 32'(empty1), 0);
    tick();
    chk("ft_hold",  rd_data1, 32'hA5);
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 32'h5A;
    tick();
    wr_en = 1'b0;
    chk("ft_count", 32'(count1), 1);
    chk("ft_next",  rd_data1, 32'h5A);
    tick();
    rd_en = 1'b0;
    chk("ft_drain", 32'(empty1), 1);

    // Asynchronous reset in the middle of a fill
    for (int i = 0; i < 5; i++) begin
      wr_en   = 1'b1;
      wr_data = 32'h71 + 32'(i);
      tick();
    end
    chk("mid_count", 32'(count0), 5);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_count", 32'(count0), 0);
    chk("ar_empty", 32'(empty0), 1);
    chk("ar_ae",    32'(ae0), 1);
    chk("ar_full",  32'(full0), 0);
    chk("ar_rd",    rd_data0, 0);
    chk("ar_ft",    32'(count1), 0);
    wr_en = 1'b0;
    tick();
    chk("ar_hold", 32'(count0), 0);
    reset = 1'b0;
    wr_en   = 1'b1;
    wr_data = 32'hC3;
    tick();
    wr_data = 32'hC4;
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("ar_first",  rd_data0, 32'hC3);
    chk("ar_ftfirst", rd_data1, 32'hC4);
    chk("ar_cnt1",   32'(count0), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
